mem_port_arbiter: RTL and testbench

- Two-master to one-port arbiter directly upstream of one port of the dual-port memory module.
- Merges requests from two requesters onto a single req/gnt/rvalid memory port, e.g. instruction and data interfaces of one core, or the two redundant cores of the FT pair.
- Uses round-robin arbitration.
- Tracks outstanding transactions in an ID FIFO so each response (rvalid/rdata) is routed back to the master that issued it.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Merges two requesters onto a single req/gnt/rvalid memory port using
//   round-robin arbitration. An outstanding-ID FIFO records which master
//   issued each accepted request, so every in-order response (rvalid/rdata)
//   is routed back to its owner. Request and response paths are purely
//   combinational, so the arbiter adds no latency.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   m0_* / m1_*                    master-side req/gnt/rvalid/addr/we/wdata/rdata
//   mem_req_o, mem_gnt_i           memory-side request handshake
//   mem_rvalid_i, mem_rdata_i      memory-side response
//   mem_addr_o, mem_we_o,
//   mem_wdata_o                    muxed request payload of the winner
//   err_o                          sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  err_o
);

    // MAX_OUTSTANDING is a power of two, so pointers wrap naturally.
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_id_t;

    // Advance a FIFO pointer by one, wrapping modulo the (power-of-two) depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    master_id_t                 rr_r;        // last handshake winner
    logic [MAX_OUTSTANDING-1:0] id_fifo_r;   // one ID bit per outstanding slot
    logic [PTR_W-1:0]           wptr_r;
    logic [PTR_W-1:0]           rptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       err_r;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    logic       full_s;
    logic       win_valid_s;
    master_id_t win_id_s;
    logic       push_s;
    logic       pop_s;
    logic       spurious_s;
    master_id_t head_id_s;

    // Outstanding-window status from registered count only; a response
    // popping this cycle does not reopen the window until the next cycle.
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        pop_s      = mem_rvalid_i & (count_r != CNT_ZERO);
        spurious_s = mem_rvalid_i & (count_r == CNT_ZERO);
        head_id_s  = master_id_t'(id_fifo_r[rptr_r]);
    end

    // Round-robin winner selection: on contention the master that did not
    // win the previous handshake goes first.
    always_comb begin
        win_valid_s = 1'b0;
        win_id_s    = MASTER_0;
        if (!full_s) begin
            case ({m1_req_i, m0_req_i})
                2'b01: begin
                    win_valid_s = 1'b1;
                    win_id_s    = MASTER_0;
                end
                2'b10: begin
                    win_valid_s = 1'b1;
                    win_id_s    = MASTER_1;
                end
                2'b11: begin
                    win_valid_s = 1'b1;
                    win_id_s    = (rr_r == MASTER_0) ? MASTER_1 : MASTER_0;
                end
                default: begin
                    win_valid_s = 1'b0;
                    win_id_s    = MASTER_0;
                end
            endcase
        end else begin
            win_valid_s = 1'b0;
            win_id_s    = MASTER_0;
        end
    end

    // Request payload mux; master 0 is presented when nobody wins so the
    // bus has a defined value.
    always_comb begin
        mem_req_o   = win_valid_s;
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_wdata_o = m0_wdata_i;
        if (win_valid_s && (win_id_s == MASTER_1)) begin
            mem_addr_o  = m1_addr_i;
            mem_we_o    = m1_we_i;
            mem_wdata_o = m1_wdata_i;
        end else begin
            mem_addr_o  = m0_addr_i;
            mem_we_o    = m0_we_i;
            mem_wdata_o = m0_wdata_i;
        end
    end

    // Grants and push qualification from the memory handshake.
    always_comb begin
        push_s   = win_valid_s & mem_gnt_i;
        m0_gnt_o = push_s & (win_id_s == MASTER_0);
        m1_gnt_o = push_s & (win_id_s == MASTER_1);
    end

    // Response routing: data fans out to both masters, only rvalid marks
    // the owner taken from the FIFO head.
    always_comb begin
        m0_rvalid_o = pop_s & (head_id_s == MASTER_0);
        m1_rvalid_o = pop_s & (head_id_s == MASTER_1);
        m0_rdata_o  = mem_rdata_i;
        m1_rdata_o  = mem_rdata_i;
        err_o       = err_r;
    end

    // Round-robin pointer: reset to master 1 so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= MASTER_1;
        end else if (push_s) begin
            rr_r <= win_id_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Outstanding-ID storage written at the write pointer on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_fifo_r <= {MAX_OUTSTANDING{1'b0}};
        end else if (push_s) begin
            id_fifo_r[wptr_r] <= win_id_s;
        end else begin
            id_fifo_r <= id_fifo_r;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error: a response arrived while nothing was outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (spurious_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A one-cycle-response memory model
// (with stall and spurious-response controls) sits on the memory port.
// Directed scenarios push the expected (owner, data) of every response into a
// scoreboard queue when stimulus is driven; a negedge monitor pops and
// compares whenever either master sees rvalid.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_i, m1_req_i;
    logic          m0_gnt_o, m1_gnt_o;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_we_i, m1_we_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          err_o;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] resp_q[$];
    logic [DW-1:0] mem [0:63];
    logic          stall;
    logic          inject;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req_i    (m0_req_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rdata_o  (m1_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory model: one-cycle response, in order, optional stall and a
    // spurious-response injector. Shares rst_n with the arbiter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q.delete();
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= 32'h0;
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    mem[mem_addr_o[7:2]] = mem_wdata_o;
                    resp_q.push_back(32'h0);
                end else begin
                    resp_q.push_back(mem[mem_addr_o[7:2]]);
                end
            end
            if (inject) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= 32'h1234_5678;
            end else if (!stall && resp_q.size() > 0) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= resp_q.pop_front();
            end else begin
                mem_rvalid_i <= 1'b0;
                mem_rdata_i  <= 32'h0;
            end
        end
    end

    // Scoreboard monitor: every master rvalid must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (m0_rvalid_o || m1_rvalid_o)) begin
            check_val("rv_exclusive", {63'h0, m0_rvalid_o & m1_rvalid_o}, 64'h0);
            check_val("rdata_fanout", {32'h0, m0_rdata_o}, {32'h0, m1_rdata_o});
            if (exp_q.size() == 0) begin
                check_val("rv_unexpected", 64'h1, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check_val("rv_owner", {63'h0, m1_rvalid_o}, {63'h0, e.id});
                check_val("rv_data", {32'h0, (m1_rvalid_o ? m1_rdata_o : m0_rdata_o)},
                          {32'h0, e.data});
            end
        end
    end

    task automatic expect_resp(input logic id, input logic [DW-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_m0(input logic req, input logic [AW-1:0] addr,
                            input logic we, input logic [DW-1:0] wdata);
        m0_req_i   = req;
        m0_addr_i  = addr;
        m0_we_i    = we;
        m0_wdata_i = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic [AW-1:0] addr,
                            input logic we, input logic [DW-1:0] wdata);
        m1_req_i   = req;
        m1_addr_i  = addr;
        m1_we_i    = we;
        m1_wdata_i = wdata;
    endtask

    task automatic idle();
        drive_m0(1'b0, 32'h0, 1'b0, 32'h0);
        drive_m1(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_grants(input string tag, input logic g0, input logic g1, input logic req);
        check_val({tag, "_gnt0"}, {63'h0, m0_gnt_o}, {63'h0, g0});
        check_val({tag, "_gnt1"}, {63'h0, m1_gnt_o}, {63'h0, g1});
        check_val({tag, "_memreq"}, {63'h0, mem_req_o}, {63'h0, req});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        check_val("rst_err", {63'h0, err_o}, 64'h0);
        check_grants("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA000_0000 + i;
        end
        mem[4] = 32'hDEAD_BEEF;
        stall     = 1'b0;
        inject    = 1'b0;
        mem_gnt_i = 1'b1;
        rst_n     = 1'b0;
        idle();
        #1;
        check_grants("reset", 1'b0, 1'b0, 1'b0);
        check_val("reset_rv0", {63'h0, m0_rvalid_o}, 64'h0);
        check_val("reset_rv1", {63'h0, m1_rvalid_o}, 64'h0);
        check_val("reset_err", {63'h0, err_o}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single master read, first with the memory withholding its grant.
        @(negedge clk);
        drive_m0(1'b1, 32'h10, 1'b0, 32'h0);
        mem_gnt_i = 1'b0;
        #1;
        check_grants("nognt", 1'b0, 1'b0, 1'b1);
        check_val("nognt_addr", {32'h0, mem_addr_o}, 64'h10);
        @(negedge clk);
        mem_gnt_i = 1'b1;
        #1;
        check_grants("single", 1'b1, 1'b0, 1'b1);
        expect_resp(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("single_rv0", {63'h0, m0_rvalid_o}, 64'h1);
        check_val("single_rv1", {63'h0, m1_rvalid_o}, 64'h0);
        check_val("single_data", {32'h0, m0_rdata_o}, 64'hDEAD_BEEF);
        idle();

        // Contention from reset: grants alternate starting with m0.
        do_reset();
        @(negedge clk);
        drive_m0(1'b1, 32'h20, 1'b0, 32'h0);
        drive_m1(1'b1, 32'h24, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_grants("contend", (i % 2) == 0, (i % 2) == 1, 1'b1);
            expect_resp((i % 2) == 1, ((i % 2) == 1) ? mem[9] : mem[8]);
        end
        @(negedge clk);
        idle();
        @(negedge clk);

        // Write by m1 then read-back by m0.
        drive_m1(1'b1, 32'h4, 1'b1, 32'h0000_0055);
        #1;
        check_grants("write", 1'b0, 1'b1, 1'b1);
        check_val("write_we", {63'h0, mem_we_o}, 64'h1);
        check_val("write_wdata", {32'h0, mem_wdata_o}, 64'h55);
        expect_resp(1'b1, 32'h0);
        @(negedge clk);
        drive_m1(1'b0, 32'h0, 1'b0, 32'h0);
        drive_m0(1'b1, 32'h4, 1'b0, 32'h0);
        #1;
        check_grants("readback", 1'b1, 1'b0, 1'b1);
        check_val("readback_we", {63'h0, mem_we_o}, 64'h0);
        expect_resp(1'b0, 32'h0000_0055);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Full backpressure: two grants, then no request until a pop lands.
        do_reset();
        @(negedge clk);
        stall = 1'b1;
        drive_m0(1'b1, 32'h30, 1'b0, 32'h0);
        drive_m1(1'b1, 32'h34, 1'b0, 32'h0);
        #1;
        check_grants("bp0", 1'b1, 1'b0, 1'b1);
        expect_resp(1'b0, mem[12]);
        @(negedge clk);
        #1;
        check_grants("bp1", 1'b0, 1'b1, 1'b1);
        expect_resp(1'b1, mem[13]);
        @(negedge clk);
        #1;
        check_grants("bp_full2", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_grants("bp_full3", 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        @(negedge clk);
        #1;
        check_val("bp_pop_rv0", {63'h0, m0_rvalid_o}, 64'h1);
        check_grants("bp_nobypass", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_grants("bp_resume", 1'b1, 1'b0, 1'b1);
        expect_resp(1'b0, mem[12]);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);

        // Spurious response: no routing, sticky error until reset.
        do_reset();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check_val("spur_rv0", {63'h0, m0_rvalid_o}, 64'h0);
        check_val("spur_rv1", {63'h0, m1_rvalid_o}, 64'h0);
        check_val("spur_err_pre", {63'h0, err_o}, 64'h0);
        @(negedge clk);
        check_val("spur_err", {63'h0, err_o}, 64'h1);
        drive_m0(1'b1, 32'h10, 1'b0, 32'h0);
        #1;
        check_grants("spur_txn", 1'b1, 1'b0, 1'b1);
        expect_resp(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        check_val("spur_sticky", {63'h0, err_o}, 64'h1);

        // Reset one cycle after a grant discards the outstanding ID.
        do_reset();
        @(negedge clk);
        stall = 1'b1;
        drive_m1(1'b1, 32'h24, 1'b0, 32'h0);
        #1;
        check_grants("mid_gnt", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        check_grants("mid_rst", 1'b0, 1'b0, 1'b0);
        check_val("mid_rst_err", {63'h0, err_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_m0(1'b1, 32'h20, 1'b0, 32'h0);
        drive_m1(1'b1, 32'h24, 1'b0, 32'h0);
        #1;
        check_grants("mid_after0", 1'b1, 1'b0, 1'b1);
        expect_resp(1'b0, mem[8]);
        @(negedge clk);
        #1;
        check_grants("mid_after1", 1'b0, 1'b1, 1'b1);
        expect_resp(1'b1, mem[9]);
        @(negedge clk);
        #1;
        check_grants("mid_full", 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        @(negedge clk);
        idle();

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        check_val("drain", exp_q.size(), 64'h0);
        check_val("end_err", {63'h0, err_o}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
